span_read_sequencer: RTL and testbench

- Drains closed spans from row_packer.
- Pops one descriptor at a time and sequences the packer's active-buffer read port over addresses 0..len-1.
- Emits a per-pixel (x, y, z) stream with valid/ready backpressure, then pulses desc_done to return the buffer to the free ring.
- Sits between row_packer and the downstream depth-test/framebuffer stage.

---
 rtl/span_seq_pkg.sv | 33 +++
 rtl/span_out_fifo.sv | 53 +++++
 rtl/span_read_sequencer.sv | 142 ++++++++++++++
 tb/tb_span_read_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/span_seq_pkg.sv
// Shared types and width helpers for the span read sequencer.
// Width helpers let each instance derive its widths from its own parameters.
package span_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int XW_DEF        = 16;
  localparam int YW_DEF        = 16;
  localparam int ZW_DEF        = 32;
  localparam int BUF_DEPTH_DEF = 256;
  localparam int OUT_DEPTH_DEF = 4;

  localparam int LEN_W  = $clog2(BUF_DEPTH_DEF + 1);
  localparam int ADDR_W = $clog2(BUF_DEPTH_DEF);
  localparam int REC_W  = XW_DEF + YW_DEF + ZW_DEF + 1;

  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int rec_width(input int xw, input int yw, input int zw);
    return xw + yw + zw + 1;
  endfunction

endpackage

// File: rtl/span_out_fifo.sv
// Small synchronous FIFO holding pixel records between the packer read port and
// the downstream stage. Pointers and count clear on reset; storage does not.
module span_out_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/span_read_sequencer.sv
// Drains one closed span at a time from the row packer buffer into a pixel stream,
// then pulses desc_done so the packer can recycle the buffer.
//
// state | meaning
// IDLE  | waiting for a descriptor; only state with desc_ready high
// READ  | issuing buffer reads under FIFO credit until the last read is captured
// DONE  | one-cycle desc_done pulse, span_count increments
module span_read_sequencer
  import span_seq_pkg::*;
#(
  parameter int XW        = 16,
  parameter int YW        = 16,
  parameter int ZW        = 32,
  parameter int BUF_DEPTH = 256,
  parameter int OUT_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           desc_valid,
  output logic                           desc_ready,
  input  logic [XW-1:0]                  desc_x0,
  input  logic [YW-1:0]                  desc_y,
  input  logic [$clog2(BUF_DEPTH+1)-1:0] desc_len,
  output logic                           desc_done,
  output logic                           read_en,
  output logic [$clog2(BUF_DEPTH)-1:0]   read_addr,
  input  logic [ZW-1:0]                  read_data,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [XW-1:0]                  pix_x,
  output logic [YW-1:0]                  pix_y,
  output logic [ZW-1:0]                  pix_z,
  output logic                           pix_last,
  output logic                           busy,
  output logic [31:0]                    span_count
);

  localparam int LW = len_width(BUF_DEPTH);
  localparam int AW = addr_width(BUF_DEPTH);
  localparam int RW = rec_width(XW, YW, ZW);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [XW-1:0] x0_q;
  logic [XW-1:0] pend_x;
  logic [YW-1:0] y_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic          pending;
  logic          pend_last;
  logic          accept;
  logic          issue;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [RW-1:0] push_rec;
  logic [RW-1:0] head_rec;

  assign accept      = desc_valid && (state == IDLE);
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, pending};
  // A read is only issued when a FIFO slot is reserved for its data.
  assign issue       = (state == READ) && (idx != len_q) && !fifo_full &&
                       (credit_used < (CW+1)'(OUT_DEPTH));
  assign push        = pending;
  assign push_rec    = {pend_x, y_q, read_data, pend_last};
  assign pop         = !fifo_empty && pix_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (desc_len == '0) ? DONE : READ;
      READ:    if (push && pend_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      span_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == DONE) span_count <= span_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x0_q      <= '0;
      y_q       <= '0;
      len_q     <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      pend_x    <= '0;
      pend_last <= 1'b0;
    end else begin
      if (accept) begin
        x0_q  <= desc_x0;
        y_q   <= desc_y;
        len_q <= desc_len;
        idx   <= '0;
      end else if (issue) begin
        idx <= idx + LW'(1);
      end
      // Read data lands one cycle after issue and is always captured then.
      pending <= issue;
      if (issue) begin
        pend_x    <= x0_q + XW'(idx);
        pend_last <= ((idx + LW'(1)) == len_q);
      end
    end
  end

  span_out_fifo #(
    .W    (RW),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .pop  (pop),
    .wdata(push_rec),
    .rdata(head_rec),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign desc_ready = (state == IDLE);
  assign desc_done  = (state == DONE);
  assign read_en    = issue;
  assign read_addr  = idx[AW-1:0];
  assign pix_valid  = !fifo_empty;
  assign {pix_x, pix_y, pix_z, pix_last} = fifo_empty ? '0 : head_rec;
  assign busy       = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_span_read_sequencer.sv
// Bench for span_read_sequencer: packer buffer model, pixel scoreboard built from
// each accepted descriptor, table vectors, random spans and timing corner cases.
module tb_span_read_sequencer;

  localparam int OUT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [15:0] desc_x0 = '0;
  logic [15:0] desc_y = '0;
  logic [8:0]  desc_len = '0;
  logic        desc_done;
  logic        read_en;
  logic [7:0]  read_addr;
  logic [31:0] read_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic [31:0] pix_z;
  logic        pix_last;
  logic        busy;
  logic [31:0] span_count;

  span_read_sequencer #(
    .XW(16), .YW(16), .ZW(32), .BUF_DEPTH(256), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_x0(desc_x0), .desc_y(desc_y), .desc_len(desc_len),
    .desc_done(desc_done),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_z(pix_z), .pix_last(pix_last),
    .busy(busy), .span_count(span_count)
  );

  always #5 clk = ~clk;

  // Packer buffer: registered read port, data held while read_en is low.
  logic [31:0] pmem [256];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) read_data <= '0;
    else if (read_en) read_data <= pmem[read_addr];
  end

  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] z;
    logic        last;
  } pix_t;

  pix_t exp_q[$];
  pix_t e_m;
  int cyc = 0, issued = 0, popped = 0, exp_addr = 0;
  int n_pix = 0, n_last = 0, n_done = 0, n_acc = 0;
  int acc_cyc = 0, done_cyc = 0, last_gap = 0;
  logic [15:0] last_x = '0;
  logic [7:0]  last_raddr = '0;

  // Scoreboard: expected pixels come straight from the descriptor and buffer contents.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      exp_q.delete();
      issued = 0;
      popped = 0;
      exp_addr = 0;
    end else begin
      if (read_en) begin
        chk(issued - popped < OUT_DEPTH, "read_credit", 64'(issued - popped), 64'(OUT_DEPTH - 1));
        chk(read_addr == 8'(exp_addr), "read_addr", 64'(read_addr), 64'(exp_addr));
        last_raddr = read_addr;
        exp_addr++;
        issued++;
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "pix_unexpected", {pix_x, pix_y, pix_z}, 64'd0);
        end else begin
          e_m = exp_q.pop_front();
          chk({pix_x, pix_y, pix_z} == {e_m.x, e_m.y, e_m.z}, "pix_xyz",
              {pix_x, pix_y, pix_z}, {e_m.x, e_m.y, e_m.z});
          chk(pix_last == e_m.last, "pix_last", 64'(pix_last), 64'(e_m.last));
        end
        popped++;
        n_pix++;
        last_x = pix_x;
        if (pix_last) n_last++;
      end
      if (desc_done) begin
        chk(!desc_ready, "done_vs_ready", 64'(desc_ready), 64'd0);
        n_done++;
        done_cyc = cyc;
      end
      if (desc_valid && desc_ready) begin
        for (int i = 0; i < int'(desc_len); i++)
          exp_q.push_back('{desc_x0 + 16'(i), desc_y, pmem[i], (i == int'(desc_len) - 1)});
        exp_addr = 0;
        n_acc++;
        last_gap = cyc - done_cyc;
        acc_cyc = cyc;
      end
    end
  end

  task automatic check_reset_vals();
    chk(desc_ready == 1'b1, "rst_desc_ready", 64'(desc_ready), 64'd1);
    chk(desc_done == 1'b0, "rst_desc_done", 64'(desc_done), 64'd0);
    chk(read_en == 1'b0, "rst_read_en", 64'(read_en), 64'd0);
    chk(read_addr == 8'd0, "rst_read_addr", 64'(read_addr), 64'd0);
    chk(pix_valid == 1'b0, "rst_pix_valid", 64'(pix_valid), 64'd0);
    chk(pix_last == 1'b0, "rst_pix_last", 64'(pix_last), 64'd0);
    chk({pix_x, pix_y, pix_z} == 64'd0, "rst_pix_data", {pix_x, pix_y, pix_z}, 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(span_count == 32'd0, "rst_span_count", 64'(span_count), 64'd0);
  endtask

  task automatic wait_ready(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (desc_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(1'b0, name, 64'd0, 64'd1);
  endtask

  task automatic present(input logic [15:0] x0, input logic [15:0] y, input int len);
    @(posedge clk); #1;
    desc_x0 = x0; desc_y = y; desc_len = 9'(len); desc_valid = 1'b1;
    wait_ready("accept_timeout");
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit got = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk); #1;
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(1'b0, "idle_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [15:0] x0;
    logic [15:0] y;
    int          len;
    int          mode;
    int          exp_pix;
    logic [15:0] exp_last_x;
  } vec_t;

  int exp_spans = 0;

  task automatic run_vec(input vec_t v);
    int p0;
    for (int i = 0; i < v.len; i++) pmem[i] = $urandom;
    rdy_mode = v.mode;
    p0 = n_pix;
    present(v.x0, v.y, v.len);
    wait_idle(3000);
    exp_spans++;
    chk(n_pix - p0 == v.exp_pix, "vec_pix_count", 64'(n_pix - p0), 64'(v.exp_pix));
    if (v.exp_pix != 0) begin
      chk(last_x == v.exp_last_x, "vec_last_x", 64'(last_x), 64'(v.exp_last_x));
      chk(last_raddr == 8'(v.len - 1), "vec_last_addr", 64'(last_raddr), 64'(v.len - 1));
    end
    chk(span_count == 32'(exp_spans), "vec_span_count", 64'(span_count), 64'(exp_spans));
  endtask

  vec_t vecs[6];

  initial begin
    int p0, l0, d0, i0;
    vec_t rv;

    vecs[0] = '{16'd10,     16'd5, 4,   0, 4,   16'd13};
    vecs[1] = '{16'd100,    16'd7, 8,   1, 8,   16'd107};
    vecs[2] = '{16'hFFF0,   16'd3, 256, 0, 256, 16'h00EF};
    vecs[3] = '{16'd0,      16'd1, 0,   0, 0,   16'd0};
    vecs[4] = '{16'hFFFE,   16'd9, 5,   2, 5,   16'h0002};
    vecs[5] = '{16'd50,     16'd2, 1,   1, 1,   16'd50};

    for (int i = 0; i < 256; i++) pmem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single span: exact cycle-by-cycle latency and output sequence.
    for (int i = 0; i < 4; i++) pmem[i] = 32'(100 + i);
    rdy_mode = 0;
    @(posedge clk); #1;
    desc_x0 = 16'd10; desc_y = 16'd5; desc_len = 9'd4; desc_valid = 1'b1;
    @(negedge clk);
    chk(desc_ready == 1'b1, "t1_accept", 64'(desc_ready), 64'd1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    @(negedge clk);
    chk(read_en && read_addr == 8'd0, "t1_first_read", {read_en, read_addr}, {1'b1, 8'd0});
    @(negedge clk);
    chk(pix_valid == 1'b0, "t1_no_pix_t2", 64'(pix_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(pix_valid == 1'b1, "t1_pix_valid", 64'(pix_valid), 64'd1);
      chk({pix_x, pix_y, pix_z} == {16'(10 + k), 16'd5, 32'(100 + k)}, "t1_pix",
          {pix_x, pix_y, pix_z}, {16'(10 + k), 16'd5, 32'(100 + k)});
      chk(pix_last == (k == 3), "t1_last", 64'(pix_last), 64'(k == 3));
      if (k == 3) chk(desc_done == 1'b1, "t1_done", 64'(desc_done), 64'd1);
    end
    @(negedge clk);
    chk(desc_done == 1'b0, "t1_done_once", 64'(desc_done), 64'd0);
    chk(span_count == 32'd1, "t1_span_count", 64'(span_count), 64'd1);
    chk(busy == 1'b0, "t1_busy", 64'(busy), 64'd0);
    exp_spans = 1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Back-to-back descriptors, second one already waiting when the first finishes.
    for (int i = 0; i < 4; i++) pmem[i] = $urandom;
    rdy_mode = 0;
    p0 = n_pix; l0 = n_last; d0 = n_done;
    @(posedge clk); #1;
    desc_x0 = 16'd20; desc_y = 16'd1; desc_len = 9'd3; desc_valid = 1'b1;
    wait_ready("b2b_accept_a");
    @(posedge clk); #1;
    desc_x0 = 16'd40; desc_y = 16'd2; desc_len = 9'd2;
    wait_ready("b2b_accept_b");
    @(posedge clk); #1;
    desc_valid = 1'b0;
    wait_idle(200);
    exp_spans += 2;
    chk(last_gap == 1, "b2b_accept_gap", 64'(last_gap), 64'd1);
    chk(n_pix - p0 == 5, "b2b_pix_count", 64'(n_pix - p0), 64'd5);
    chk(n_last - l0 == 2, "b2b_last_count", 64'(n_last - l0), 64'd2);
    chk(n_done - d0 == 2, "b2b_done_count", 64'(n_done - d0), 64'd2);
    chk(span_count == 32'(exp_spans), "b2b_span_count", 64'(span_count), 64'(exp_spans));

    // Zero-length span: no reads, no pixels, one done pulse shortly after accept.
    i0 = issued; p0 = n_pix; d0 = n_done;
    present(16'd7, 16'd7, 0);
    wait_idle(20);
    exp_spans++;
    chk(issued == i0, "len0_reads", 64'(issued - i0), 64'd0);
    chk(n_pix == p0, "len0_pixels", 64'(n_pix - p0), 64'd0);
    chk(n_done == d0 + 1, "len0_done", 64'(n_done - d0), 64'd1);
    chk(done_cyc - acc_cyc >= 1 && done_cyc - acc_cyc <= 2, "len0_done_delay",
        64'(done_cyc - acc_cyc), 64'd1);
    chk(span_count == 32'(exp_spans), "len0_span_count", 64'(span_count), 64'(exp_spans));

    for (int r = 0; r < 15; r++) begin
      rv.x0 = 16'($urandom);
      rv.y = 16'($urandom);
      rv.len = $urandom_range(0, 24);
      rv.mode = $urandom_range(0, 2);
      rv.exp_pix = rv.len;
      rv.exp_last_x = rv.x0 + 16'(rv.len - 1);
      run_vec(rv);
    end

    // Reset in the middle of a span abandons it; a fresh span then runs cleanly.
    for (int i = 0; i < 8; i++) pmem[i] = $urandom;
    rdy_mode = 0;
    p0 = n_pix;
    present(16'd300, 16'd4, 8);
    begin
      bit got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk); #1;
        if (n_pix - p0 >= 3) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) chk(1'b0, "rst_mid_timeout", 64'(n_pix - p0), 64'd3);
    end
    rstn = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_spans = 0;
    rv = '{16'd500, 16'd6, 2, 0, 2, 16'd501};
    run_vec(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x0, required 0x1");
    $fatal(1, "timeout");
  end

endmodule
